gradient_deskew_buffer: RTL and testbench
=========================================

Name: gradient_deskew_buffer

Overview:
Sits directly downstream of the per-column MSE loss stage. Captures column-skewed gradient words (column i arrives i cycles after column 0) into per-column FIFOs. Re-emits them as row-aligned N-wide gradient vectors over a valid/ready handshake to the backprop/writeback path. The loss stage cannot be back-pressured, so the block raises an early stall warning and a sticky overflow error instead.

Parameters:
N, 2, number of gradient columns (≥1)
DEPTH, 8, entries per column FIFO; power of two, ≥2
STALL_MARGIN, 2, stall_out asserts when any column's free entries ≤ STALL_MARGIN (must be < DEPTH)
CLIP_LIMIT, 16'sh0400, positive clip magnitude used only under GRAD_CLIP_EN

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
grad_in  in  N×16 signed  per-column gradient word (Q8.8)
valid_in  in  N  per-column write strobe
flush  in  1  synchronous clear of all FIFOs and error flag
row_out  out  N×16 signed  head-of-FIFO row, column i in slice i
row_valid  out  1  every column FIFO non-empty
row_ready  in  1  consumer accepts row
stall_out  out  1  early-warning to sequencer to pause loss issue
overflow_err  out  1  sticky: a write was dropped into a full column

Behaviour:
- Reset (async assert): all read/write pointers, counts and storage cleared to 0. overflow_err=0. Consequently row_valid=0, row_out=0, stall_out=0. Release is synchronous to clk.
- Per column i: push when valid_in[i]. Pop when row_valid && row_ready; the pop applies to all columns together in the same cycle.
- FIFOs are show-ahead: row_out[i] is the current head of column i, combinational from storage/read pointer.
- row_valid = AND of all column non-empty flags.
- Latency: a write at edge t that completes a row gives row_valid=1 after edge t, i.e. in cycle t+1. No combinational path from valid_in or grad_in to row_out or row_valid.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is $clog2(DEPTH+1) bits.
- Full column with valid_in[i] and no pop: write dropped, count unchanged, overflow_err set.
- Full column with valid_in[i] and a pop in the same cycle: write accepted, count unchanged, no error.
- Empty columns are never popped, because row_valid=0 whenever any column is empty.
- Columns holding data while another column is empty keep that data; partial rows are never emitted.
- stall_out is registered: 1 in the cycle after any column's count ≥ DEPTH−STALL_MARGIN, 0 otherwise.
- flush: next edge sets all pointers and counts to 0 and clears overflow_err. Storage contents are don't-care, but row_out must read 0 while row_valid=0. flush wins over same-cycle valid_in (inputs dropped) and over a same-cycle pop (no handshake is counted).
- row_out must hold stable while row_valid && !row_ready.
- Arithmetic: pass-through, no width change, except under GRAD_CLIP_EN.

Optional Feature:
Macro GRAD_CLIP_EN.
- Defined: each row_out slice is saturated to [−CLIP_LIMIT, +CLIP_LIMIT] on the output side after the FIFO. Stored values remain unclipped.
- Not defined: row_out is the raw FIFO head, and CLIP_LIMIT is unused.
- Clipping never affects row_valid, counts or errors.

Decomposition:
- Shared package tpu_pkg: typedef logic signed [15:0] fixed16_t; localparam DATA_W=16; function sat16(fixed16_t v, fixed16_t lim).
- Sub-module grad_col_fifo: one single-column show-ahead FIFO with push, pop, flush, full, empty and count. It is instantiated N times in a generate loop.
- Top level holds the row_valid AND, the common pop, stall and error logic, and the optional clip.

Test Plan:
1. N=2, DEPTH=4: col0 writes 0x0100 at cycle 0, col1 writes 0xFF00 at cycle 1, row_ready=1 → row_valid=1 in cycle 2 only, with row_out={0xFF00,0x0100}; then row_valid=0.
2. Skewed stream of 4 rows with row_ready=0 → after all written, counts=4 each, stall_out=1 (DEPTH−2 reached at count 2). A 5th col0 write sets overflow_err=1 and col0 count stays 4. row_out holds row 0 stable.
3. Full col0 with simultaneous valid_in[0] and pop (row_ready=1) → write accepted, no overflow_err, and the new value emerges as the 4th subsequent row.
4. Pointer wrap: 20 rows streamed continuously with row_ready=1 → all 20 rows emerge in order, with no errors or duplicates.
5. flush asserted together with valid_in=2'b11 and a pending row → next cycle row_valid=0, row_out=0, overflow_err=0; the flushed inputs never appear.
6. Async rst pulsed mid-stream between clock edges → outputs go to 0 immediately, without waiting for an edge. With GRAD_CLIP_EN and CLIP_LIMIT=0x0400, writes of 0x7000 and 0x8000 read back as 0x0400 and 0xFC00.

Source files
------------

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared fixed-point gradient type and saturation helper
package tpu_pkg;
  localparam int DATA_W = 16;
  typedef logic signed [DATA_W-1:0] fixed16_t;
  function automatic fixed16_t sat16(fixed16_t v, fixed16_t lim);
    return v > lim ? lim : (v < -lim ? -lim : v);
  endfunction
endpackage

// File: rtl/grad_col_fifo.sv
// grad_col_fifo: single-column show-ahead FIFO with flush and occupancy count
module grad_col_fifo
  import tpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fixed16_t                     din,
  output fixed16_t                     head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  fixed16_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign rd    = pop && !empty && !flush;
  // a full column still accepts a write when the same edge frees a slot
  assign wr    = push && (!full || rd) && !flush;
  assign head  = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= din;
        wp      <= wp + AW'(1);
      end
      if (rd) rp <= rp + AW'(1);
      count <= count + CW'(wr) - CW'(rd);
    end
endmodule

// File: rtl/gradient_deskew_buffer.sv
// gradient_deskew_buffer: deskews column-staggered gradients into row-aligned vectors.
// Define GRAD_CLIP_EN to saturate each output slice to +/-CLIP_LIMIT.
module gradient_deskew_buffer
  import tpu_pkg::*;
#(
  parameter int       N            = 2,
  parameter int       DEPTH        = 8,
  parameter int       STALL_MARGIN = 2,
  parameter fixed16_t CLIP_LIMIT   = 16'sh0400
) (
  input  logic             clk,
  input  logic             rst,
  input  fixed16_t [N-1:0] grad_in,
  input  logic [N-1:0]     valid_in,
  input  logic             flush,
  output fixed16_t [N-1:0] row_out,
  output logic             row_valid,
  input  logic             row_ready,
  output logic             stall_out,
  output logic             overflow_err
);
  localparam int CW = $clog2(DEPTH + 1);
  fixed16_t [N-1:0] head;
  logic [N-1:0] full, empty, near_full;
  logic [N-1:0][CW-1:0] count;
  logic pop;
  assign row_valid = ~|empty;
  assign pop       = row_valid && row_ready;
  for (genvar i = 0; i < N; i++) begin : g_col
    grad_col_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (valid_in[i]),
      .pop   (pop),
      .flush (flush),
      .din   (grad_in[i]),
      .head  (head[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .count (count[i])
    );
    assign near_full[i] = count[i] >= CW'(DEPTH - STALL_MARGIN);
  end
  // gating on row_valid keeps stale storage invisible after a flush
`ifdef GRAD_CLIP_EN
  always_comb
    for (int j = 0; j < N; j++) row_out[j] = row_valid ? sat16(head[j], CLIP_LIMIT) : '0;
`else
  assign row_out = row_valid ? head : '0;
  logic unused_clip;
  assign unused_clip = ^CLIP_LIMIT;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_out    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      stall_out    <= |near_full;
      overflow_err <= !flush && (overflow_err || ((|(valid_in & full)) && !pop));
    end
endmodule

// File: tb/tb_gradient_deskew_buffer.sv
// tb_gradient_deskew_buffer: table vectors, directed corners and queue-model random test
module tb_gradient_deskew_buffer;
  localparam int N = 2, DEPTH = 4, SM = 2;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, row_ready = 1'b0;
  logic row_valid, stall_out, overflow_err;
  logic [N-1:0] valid_in = '0;
  logic [N-1:0][15:0] grad_in = '0;
  logic [N-1:0][15:0] row_out;
  int checks = 0, errors = 0, rows_seen = 0, rows_base;

  gradient_deskew_buffer #(.N(N), .DEPTH(DEPTH), .STALL_MARGIN(SM), .CLIP_LIMIT(16'sh0400)) dut (
    .clk(clk), .rst(rst), .grad_in(grad_in), .valid_in(valid_in), .flush(flush),
    .row_out(row_out), .row_valid(row_valid), .row_ready(row_ready),
    .stall_out(stall_out), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  logic [15:0] mq [N][$];
  logic m_ovf = 1'b0, m_stall = 1'b0;

  function automatic logic [15:0] clipv(logic [15:0] v);
`ifdef GRAD_CLIP_EN
    if ($signed(v) > 16'sh0400) return 16'h0400;
    if ($signed(v) < -16'sh0400) return 16'hFC00;
`endif
    return v;
  endfunction

  function automatic logic m_rv();
    for (int i = 0; i < N; i++) if (mq[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_ovf = 1'b0;
    m_stall = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] v, input logic [N-1:0][15:0] g, input logic r, input logic f);
    logic p;
    p = m_rv() && r;
    m_stall = 1'b0;
    for (int i = 0; i < N; i++) if (mq[i].size() >= DEPTH - SM) m_stall = 1'b1;
    if (f) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_ovf = 1'b0;
    end else
      for (int i = 0; i < N; i++) begin
        if (p) void'(mq[i].pop_front());
        if (v[i]) begin
          if (mq[i].size() < DEPTH) mq[i].push_back(g[i]);
          else m_ovf = 1'b1;
        end
      end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic rv;
    logic [N-1:0][15:0] eo;
    rv = m_rv();
    eo = '0;
    if (rv) for (int i = 0; i < N; i++) eo[i] = clipv(mq[i][0]);
    check({tag, " row_valid"}, 32'(row_valid), 32'(rv));
    check({tag, " row_out"}, 32'(row_out), 32'(eo));
    check({tag, " stall_out"}, 32'(stall_out), 32'(m_stall));
    check({tag, " overflow_err"}, 32'(overflow_err), 32'(m_ovf));
  endtask

  task automatic cyc(input logic [N-1:0] v, input logic [15:0] g0, input logic [15:0] g1,
                     input logic r, input logic f, input string tag);
    valid_in = v;
    grad_in = {g1, g0};
    row_ready = r;
    flush = f;
    #1;
    check_model(tag);
    if (row_valid && row_ready && !flush) rows_seen++;
    @(posedge clk);
    model_step(v, {g1, g0}, r, f);
    #1;
  endtask

  typedef struct {
    logic [1:0] v; logic [15:0] g0, g1; logic r, f;
    logic rv; logic [15:0] o0, o1; logic st, ov;
  } vec_t;
  vec_t tv [18];

  initial begin
    tv[0]  = '{2'b01, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tv[1]  = '{2'b10, 16'h0000, 16'hFF00, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tv[2]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0100, 16'hFF00, 1'b0, 1'b0};
    tv[3]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tv[4]  = '{2'b01, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tv[5]  = '{2'b11, 16'h0011, 16'h0020, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tv[6]  = '{2'b11, 16'h0012, 16'h0021, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0020, 1'b0, 1'b0};
    tv[7]  = '{2'b11, 16'h0013, 16'h0022, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0020, 1'b1, 1'b0};
    tv[8]  = '{2'b10, 16'h0000, 16'h0023, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0020, 1'b1, 1'b0};
    tv[9]  = '{2'b01, 16'h0014, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0020, 1'b1, 1'b0};
    tv[10] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0020, 1'b1, 1'b1};
    tv[11] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0020, 1'b1, 1'b1};
    tv[12] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0011, 16'h0021, 1'b1, 1'b1};
    tv[13] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0012, 16'h0022, 1'b1, 1'b1};
    tv[14] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0013, 16'h0023, 1'b1, 1'b1};
    tv[15] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tv[16] = '{2'b11, 16'h0AAA, 16'h0BBB, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tv[17] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};

    #2;
    check("reset row_valid", 32'(row_valid), 32'd0);
    check("reset row_out", 32'(row_out), 32'd0);
    check("reset stall_out", 32'(stall_out), 32'd0);
    check("reset overflow_err", 32'(overflow_err), 32'd0);
    model_reset();
    #5 rst = 1'b0;
    @(posedge clk);
    #1;

    // single row, skewed stream with back-pressure, overflow, drain, flush
    for (int k = 0; k < 18; k++) begin
      valid_in = tv[k].v;
      grad_in = {tv[k].g1, tv[k].g0};
      row_ready = tv[k].r;
      flush = tv[k].f;
      #1;
      check($sformatf("vec%0d row_valid", k), 32'(row_valid), 32'(tv[k].rv));
      check($sformatf("vec%0d row_out", k), 32'(row_out), {clipv(tv[k].o1), clipv(tv[k].o0)});
      check($sformatf("vec%0d stall_out", k), 32'(stall_out), 32'(tv[k].st));
      check($sformatf("vec%0d overflow_err", k), 32'(overflow_err), 32'(tv[k].ov));
      @(posedge clk);
      model_step(tv[k].v, {tv[k].g1, tv[k].g0}, tv[k].r, tv[k].f);
      #1;
    end

    // full column written during a pop is accepted
    for (int k = 0; k < 5; k++)
      cyc({k >= 1, k < 4}, 16'(16'h0030 + k), 16'(16'h0040 + k - 1), 1'b0, 1'b0, "fill");
    cyc(2'b01, 16'h0055, 16'h0000, 1'b1, 1'b0, "full_pop");
    check("full_pop no overflow", 32'(overflow_err), 32'd0);
    cyc(2'b10, 16'h0000, 16'h0066, 1'b0, 1'b0, "full_pop_c1");
    for (int k = 0; k < 6; k++) cyc(2'b00, 16'h0, 16'h0, 1'b1, 1'b0, "full_pop_drain");

    // 20 rows streamed continuously wrap the pointers several times
    rows_base = rows_seen;
    for (int k = 0; k <= 20; k++)
      cyc({k >= 1, k < 20}, 16'(16'h0100 + k), 16'(16'h0200 + k - 1), 1'b1, 1'b0, "wrap");
    for (int k = 0; k < 3; k++) cyc(2'b00, 16'h0, 16'h0, 1'b1, 1'b0, "wrap_drain");
    check("wrap row count", 32'(rows_seen - rows_base), 32'd20);
    check("wrap no overflow", 32'(overflow_err), 32'd0);

    // flush beats same-cycle writes and a pending pop
    for (int k = 0; k < 5; k++) cyc(2'b01, 16'(16'h0070 + k), 16'h0, 1'b0, 1'b0, "pre_flush");
    cyc(2'b10, 16'h0, 16'h0080, 1'b0, 1'b0, "pre_flush_c1");
    cyc(2'b11, 16'h0DEA, 16'h0BEE, 1'b1, 1'b1, "flush");
    check("post_flush row_valid", 32'(row_valid), 32'd0);
    check("post_flush row_out", 32'(row_out), 32'd0);
    check("post_flush overflow_err", 32'(overflow_err), 32'd0);
    cyc(2'b01, 16'h0011, 16'h0, 1'b1, 1'b0, "post_flush");
    cyc(2'b10, 16'h0, 16'h0022, 1'b1, 1'b0, "post_flush");
    cyc(2'b00, 16'h0, 16'h0, 1'b1, 1'b0, "post_flush");

    for (int k = 0; k < 600; k++)
      cyc(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
          $urandom_range(0, 9) < 6, $urandom_range(0, 59) == 0, "rand");

    // async reset between edges
    cyc(2'b01, 16'h0101, 16'h0, 1'b0, 1'b0, "pre_rst");
    for (int k = 0; k < 4; k++) cyc(2'b11, 16'(16'h0102 + k), 16'(16'h0201 + k), 1'b0, 1'b0, "pre_rst");
    cyc(2'b01, 16'h0111, 16'h0, 1'b0, 1'b0, "pre_rst");
    valid_in = '0;
    #2 rst = 1'b1;
    #1;
    check("async_rst row_valid", 32'(row_valid), 32'd0);
    check("async_rst row_out", 32'(row_out), 32'd0);
    check("async_rst stall_out", 32'(stall_out), 32'd0);
    check("async_rst overflow_err", 32'(overflow_err), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(2'b01, 16'h0033, 16'h0, 1'b1, 1'b0, "post_rst");
    cyc(2'b10, 16'h0, 16'h0044, 1'b1, 1'b0, "post_rst");
    cyc(2'b00, 16'h0, 16'h0, 1'b1, 1'b0, "post_rst");

`ifdef GRAD_CLIP_EN
    cyc(2'b01, 16'h7000, 16'h0, 1'b0, 1'b0, "clip");
    cyc(2'b10, 16'h0, 16'h8000, 1'b0, 1'b0, "clip");
    check("clip row_out", 32'(row_out), 32'hFC000400);
    cyc(2'b00, 16'h0, 16'h0, 1'b1, 1'b0, "clip_drain");
`endif

    cyc(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, "final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
